// File: rtl/clk_div_frac_prog.sv
// Runtime-programmable fractional clock divider.
// Average output period is cfg_num/cfg_den input cycles, built from periods of Q and Q+1
// cycles spread evenly by a first-order accumulator. Q and R come from an on-chip sequential
// restoring divider. A new ratio is applied only at a period boundary.
// Optional feature: define CLK_DIV_FRAC_DUTY50_EN for a ~50% duty output; otherwise clk_div
// is a one-cycle pulse identical to div_tick.
module clk_div_frac_prog #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_vld,
  output logic         cfg_rdy,
  input  logic [W-1:0] cfg_num,
  input  logic [W-1:0] cfg_den,
  output logic         cfg_err,
  output logic         clk_div,
  output logic         div_tick
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Divider state: rem/quo/den hold the finished result while pend_q is set.
  logic            busy_q, pend_q;
  logic [CntW-1:0] step_q;
  logic [W-1:0]    rem_q, quo_q, den_q;

  // Applied ratio and period generator state.
  state_e          state_q;
  logic [W-1:0]    q_q, r_q, d_q;
  logic [W:0]      acc_q;
  logic [W-1:0]    cnt_q, len_q;
  logic            active_q;

  logic            xfer, legal;
  logic [W-1:0]    st_rem_in, st_quo_in, st_den_in, st_rem_out, st_quo_out;
  logic [W:0]      trial, diff;

  logic            period_end, apply, start, long_per;
  logic [W-1:0]    use_q, use_r, use_d, new_len, nxt_cnt;
  logic [W:0]      sum, new_acc;

  assign cfg_rdy = !busy_q && !pend_q;
  assign xfer    = cfg_vld && cfg_rdy;
  // N >= 2D guarantees every period is at least two cycles long.
  assign legal   = (cfg_den != '0) && ({1'b0, cfg_num} >= {cfg_den, 1'b0});

  // One restoring-division step; the transfer cycle itself performs the first step.
  always_comb begin
    st_rem_in = xfer ? '0 : rem_q;
    st_quo_in = xfer ? cfg_num : quo_q;
    st_den_in = xfer ? cfg_den : den_q;
    trial     = {st_rem_in, st_quo_in[W-1]};
    diff      = trial - {1'b0, st_den_in};
    if (trial >= {1'b0, st_den_in}) begin
      st_rem_out = diff[W-1:0];
      st_quo_out = {st_quo_in[W-2:0], 1'b1};
    end else begin
      st_rem_out = trial[W-1:0];
      st_quo_out = {st_quo_in[W-2:0], 1'b0};
    end
  end

  // Config handshake, legality check and sequential divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      step_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && !legal;
      if (xfer && legal) begin
        rem_q  <= st_rem_out;
        quo_q  <= st_quo_out;
        den_q  <= cfg_den;
        step_q <= CntW'(W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= st_rem_out;
        quo_q  <= st_quo_out;
        step_q <= step_q - 1'b1;
        if (step_q == CntW'(1)) begin
          busy_q <= 1'b0;
          pend_q <= 1'b1;
        end
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Period boundary, pending-ratio apply and next period length.
  always_comb begin
    period_end = active_q && (cnt_q == len_q - 1'b1);
    apply      = pend_q && ((state_q == StIdle) || !en || period_end);
    start      = en && ((state_q == StRun) || apply) && (!active_q || period_end);
    use_q      = apply ? quo_q : q_q;
    use_r      = apply ? rem_q : r_q;
    use_d      = apply ? den_q : d_q;
    // A freshly applied ratio starts from a cleared accumulator.
    sum        = (apply ? '0 : acc_q) + {1'b0, use_r};
    long_per   = (sum >= {1'b0, use_d});
    new_len    = long_per ? use_q + 1'b1 : use_q;
    new_acc    = long_per ? sum - {1'b0, use_d} : sum;
    nxt_cnt    = cnt_q + 1'b1;
  end

`ifdef CLK_DIV_FRAC_DUTY50_EN
  logic [W:0] half_len;
  assign half_len = ({1'b0, len_q} + 1'b1) >> 1;
`endif

  // Output FSM: ratio load, period counting and registered clk_div/div_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      clk_div  <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      if (apply) begin
        state_q <= StRun;
        q_q     <= quo_q;
        r_q     <= rem_q;
        d_q     <= den_q;
        acc_q   <= '0;
      end
      if (!en) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
        acc_q    <= '0;
        clk_div  <= 1'b0;
        div_tick <= 1'b0;
      end else if (start) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
        len_q    <= new_len;
        acc_q    <= new_acc;
        clk_div  <= 1'b1;
        div_tick <= 1'b1;
      end else if (active_q) begin
        cnt_q    <= nxt_cnt;
        div_tick <= 1'b0;
`ifdef CLK_DIV_FRAC_DUTY50_EN
        clk_div  <= ({1'b0, nxt_cnt} < half_len);
`else
        clk_div  <= 1'b0;
`endif
      end else begin
        clk_div  <= 1'b0;
        div_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_frac_prog.sv
// Directed bench for clk_div_frac_prog: ratio load latency, Bresenham period patterns,
// illegal ratio rejection, boundary-aligned reload, enable drop and reset during division.
module tb_clk_div_frac_prog;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cfg_vld = 1'b0;
  logic [W-1:0] cfg_num = '0;
  logic [W-1:0] cfg_den = '0;
  logic         cfg_rdy, cfg_err, clk_div, div_tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_frac_prog #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_vld  (cfg_vld),
    .cfg_rdy  (cfg_rdy),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_err  (cfg_err),
    .clk_div  (clk_div),
    .div_tick (div_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // High cycles after the tick cycle within a period of length len.
  function automatic int exp_hi(input int len);
`ifdef CLK_DIV_FRAC_DUTY50_EN
    return (len + 1) / 2 - 1;
`else
    return 0;
`endif
  endfunction

  // Offer a ratio for one cycle; returns after the transfer edge.
  task automatic send(input logic [W-1:0] num, input logic [W-1:0] den);
    check("rdy_before_send", int'(cfg_rdy), 1);
    cfg_num = num;
    cfg_den = den;
    cfg_vld = 1'b1;
    cycle();
    cfg_vld = 1'b0;
  endtask

  // Run until the next div_tick; 'elapsed' cycles of this period have already passed.
  task automatic expect_period(input string tag, input int elapsed, input int exp_len,
                               input bit chk_duty);
    int n;
    int hi;
    bit got;
    n = elapsed;
    hi = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      cycle();
      n++;
      if (div_tick) got = 1'b1;
      else if (clk_div) hi++;
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_clk_at_tick"}, int'(clk_div), 1);
    if (chk_duty) check({tag, "_high"}, hi, exp_hi(exp_len));
  endtask

  int p76[10] = '{7, 8, 7, 8, 8, 7, 8, 7, 8, 8};
  int p30[4]  = '{7, 8, 7, 8};

  initial begin
    int nt;
    // Reset values
    repeat (3) cycle();
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_div_tick", int'(div_tick), 0);
    check("rst_cfg_rdy", int'(cfg_rdy), 1);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) cycle();
    check("idle_no_clk", int'(clk_div), 0);

    // 76/10 from idle: first tick W cycles after the transfer edge
    send(8'd76, 8'd10);
    check("busy_rdy", int'(cfg_rdy), 0);
    expect_period("first_tick", 0, W, 1'b0);
    check("rdy_after_apply", int'(cfg_rdy), 1);
    foreach (p76[i]) expect_period($sformatf("p76_%0d", i), 0, p76[i], 1'b1);

    // Illegal 15/8 mid-period: one err pulse, output unaffected
    send(8'd15, 8'd8);
    check("ill_err_pulse", int'(cfg_err), 1);
    check("ill_rdy", int'(cfg_rdy), 1);
    cycle();
    check("ill_err_clear", int'(cfg_err), 0);
    expect_period("ill_p0", 2, 7, 1'b0);
    expect_period("ill_p1", 0, 8, 1'b1);

    // Reload 30/4 mid-period: old ratio finishes, then 7,8,7,8 from acc=0
    send(8'd30, 8'd4);
    check("reload_rdy_low", int'(cfg_rdy), 0);
    expect_period("reload_cur", 1, 7, 1'b0);
    expect_period("reload_old", 0, 8, 1'b1);
    check("reload_rdy_back", int'(cfg_rdy), 1);
    foreach (p30[i]) expect_period($sformatf("p30_%0d", i), 0, p30[i], 1'b1);

    // Enable dropped for 5 cycles mid-period
    repeat (3) cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("en_low_out_%0d", i), int'({clk_div, div_tick}), 0);
    end
    en = 1'b1;
    cycle();
    check("en_back_tick", int'(div_tick), 1);
    foreach (p30[i]) expect_period($sformatf("en_p30_%0d", i), 0, p30[i], 1'b1);

    // Integer ratio 100/10 after a reload: periods of exactly 10
    send(8'd100, 8'd10);
    expect_period("int_cur", 1, 7, 1'b0);
    expect_period("int_old", 0, 8, 1'b1);
    expect_period("int_p0", 0, 10, 1'b1);
    expect_period("int_p1", 0, 10, 1'b1);

    // Reset during division: everything back to reset, no ticks afterwards
    send(8'd76, 8'd10);
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", int'(cfg_rdy), 1);
    check("mid_rst_out", int'({clk_div, div_tick}), 0);
    #2;
    rst_n = 1'b1;
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (div_tick || clk_div) nt++;
    end
    check("post_rst_no_tick", nt, 0);
    check("post_rst_rdy", int'(cfg_rdy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
